examp2_and_checker: RTL and testbench

EXAMP2_AND_CHECKER -- requirements
Module: examp2_and_checker

---
 rtl/examp2_and_checker.sv | 117 +++++++++++
 tb/tb_examp2_and_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/examp2_and_checker.sv
// Self-checking monitor for a registered AND-gate DUT: predicts a&b, delays the
// prediction by LATENCY cycles and compares it with the DUT's returned result.
module examp2_and_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  system_clock,
    input  logic                  system_rst_n,
    input  logic                  start,
    input  logic [7:0]            num_vectors,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] first_data_in,
    input  logic [DATA_WIDTH-1:0] second_data_in,
    input  logic [DATA_WIDTH-1:0] dut_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            vector_count,
    output logic [7:0]            error_count,
    output logic [7:0]            first_fail_index
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] num_q, num_d;
    logic [7:0] vec_cnt_q, vec_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] first_fail_q, first_fail_d;
    logic       pass_q, pass_d;

    logic [LATENCY-1:0]                 vld_q, vld_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] exp_q, exp_d;

    logic in_run;
    logic compare;
    logic mismatch;

    assign in_run   = (state_q == ST_RUN);
    assign compare  = in_run && vld_q[LATENCY-1];
    assign mismatch = compare && (exp_q[LATENCY-1] != dut_data_out);

    // Valid bits only advance while in RUN, so leaving RUN or accepting a start flushes the pipe.
    always_comb begin
        vld_d    = '0;
        exp_d    = exp_q;
        vld_d[0] = in_run && valid_in;
        exp_d[0] = first_data_in & second_data_in;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = in_run && vld_q[i-1];
            exp_d[i] = exp_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        vec_cnt_d    = vec_cnt_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d        = num_vectors;
                    vec_cnt_d    = 8'd0;
                    err_cnt_d    = 8'd0;
                    first_fail_d = 8'd0;
                    state_d      = (num_vectors == 8'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (compare) begin
                    vec_cnt_d = vec_cnt_q + 8'd1;
                    if (mismatch) begin
                        if (err_cnt_q == 8'd0) first_fail_d = vec_cnt_q;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (vec_cnt_q + 8'd1 == num_q) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pass_d = (state_d == ST_DONE) && (err_cnt_d == 8'd0);
    end

    always_ff @(posedge system_clock or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state_q      <= ST_IDLE;
            num_q        <= 8'd0;
            vec_cnt_q    <= 8'd0;
            err_cnt_q    <= 8'd0;
            first_fail_q <= 8'd0;
            pass_q       <= 1'b0;
            vld_q        <= '0;
            exp_q        <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            vec_cnt_q    <= vec_cnt_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            vld_q        <= vld_d;
            exp_q        <= exp_d;
        end
    end

    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign vector_count     = vec_cnt_q;
    assign error_count      = err_cnt_q;
    assign first_fail_index = first_fail_q;

endmodule

// File: tb/tb_examp2_and_checker.sv
// Bench for examp2_and_checker: two checkers (LATENCY 1 and 2) watch one operand
// stream feeding a behavioural AND-gate DUT with injectable result corruption.
module tb_examp2_and_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_vectors = 8'd0;
    logic       valid_in = 1'b0;
    logic [7:0] op_a_in = 8'd0;
    logic [7:0] op_b_in = 8'd0;
    logic [7:0] corrupt = 8'd0;
    logic [7:0] and_d1 = 8'd0;
    logic [7:0] and_d2 = 8'd0;

    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] vc1, ec1, ff1, vc2, ec2, ff2;

    logic [7:0] op_a [300];
    logic [7:0] op_b [300];
    logic [7:0] mask [300];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural registered AND-gate DUT; corrupt flips result bits to force mismatches.
    always @(posedge clk) begin
        and_d1 <= (op_a_in & op_b_in) ^ corrupt;
        and_d2 <= and_d1;
    end

    examp2_and_checker #(.DATA_WIDTH(8), .LATENCY(1)) u_chk1 (
        .system_clock(clk), .system_rst_n(rst_n), .start(start), .num_vectors(num_vectors),
        .valid_in(valid_in), .first_data_in(op_a_in), .second_data_in(op_b_in),
        .dut_data_out(and_d1), .busy(busy1), .done(done1), .pass(pass1),
        .vector_count(vc1), .error_count(ec1), .first_fail_index(ff1)
    );

    examp2_and_checker #(.DATA_WIDTH(8), .LATENCY(2)) u_chk2 (
        .system_clock(clk), .system_rst_n(rst_n), .start(start), .num_vectors(num_vectors),
        .valid_in(valid_in), .first_data_in(op_a_in), .second_data_in(op_b_in),
        .dut_data_out(and_d2), .busy(busy2), .done(done2), .pass(pass2),
        .vector_count(vc2), .error_count(ec2), .first_fail_index(ff2)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string name, input logic b, input logic d, input logic p,
                              input logic [7:0] vc, input logic [7:0] ec, input logic [7:0] ff,
                              input int n, input int exp_err, input int exp_ff);
        check_output({name, "_busy"}, 32'(b), 32'd0);
        check_output({name, "_done"}, 32'(d), 32'd1);
        check_output({name, "_pass"}, 32'(p), (exp_err == 0) ? 32'd1 : 32'd0);
        check_output({name, "_vector_count"}, 32'(vc), 32'(n));
        check_output({name, "_error_count"}, 32'(ec), 32'(exp_err));
        check_output({name, "_first_fail"}, 32'(ff), 32'(exp_ff));
    endtask

    // Run-level reference: count corrupted vectors, note the first one, saturate at 255.
    task automatic model_run(input int base, input int n, output int exp_err, output int exp_ff);
        int errs = 0;
        exp_ff = 0;
        for (int i = 0; i < n; i++) begin
            if (mask[base + i] != 8'd0) begin
                if (errs == 0) exp_ff = i;
                errs++;
            end
        end
        exp_err = (errs > 255) ? 255 : errs;
    endtask

    task automatic apply_stimulus(input string name, input int base, input int n,
                                  input int gap, input int restart_at);
        int exp_err, exp_ff;
        @(negedge clk);
        start       = 1'b1;
        num_vectors = 8'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check_output({name, "_zero_done1"}, 32'(done1), 32'd1);
            check_output({name, "_zero_done2"}, 32'(done2), 32'd1);
        end else begin
            check_output({name, "_busy_start1"}, 32'(busy1), 32'd1);
            check_output({name, "_busy_start2"}, 32'(busy2), 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            op_a_in  = op_a[base + i];
            op_b_in  = op_b[base + i];
            corrupt  = mask[base + i];
            if (i == restart_at) begin
                start       = 1'b1;
                num_vectors = 8'd5;
            end
            @(negedge clk);
            valid_in = 1'b0;
            start    = 1'b0;
            corrupt  = 8'd0;
            repeat (gap) @(negedge clk);
        end
        for (int c = 0; c < 20; c++) begin
            if (done1 && done2) break;
            @(negedge clk);
        end
        check_output({name, "_reach_done"}, 32'(done1 && done2), 32'd1);
        model_run(base, n, exp_err, exp_ff);
        check_inst({name, "_l1"}, busy1, done1, pass1, vc1, ec1, ff1, n, exp_err, exp_ff);
        check_inst({name, "_l2"}, busy2, done2, pass2, vc2, ec2, ff2, n, exp_err, exp_ff);
    endtask

    initial begin
        int n, gap;
        #2;
        check_output("reset_l1", 32'({busy1, done1, pass1, vc1, ec1, ff1}), 32'd0);
        check_output("reset_l2", 32'({busy2, done2, pass2, vc2, ec2, ff2}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single correct vector");
        op_a[0] = 8'hD5; op_b[0] = 8'hAA; mask[0] = 8'h00;
        apply_stimulus("one_vec", 0, 1, 0, -1);

        $display("[TB] four vectors, vector 2 returns 0x81");
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'hD5; op_b[i] = 8'hAA; mask[i] = (i == 2) ? 8'h01 : 8'h00;
        end
        apply_stimulus("four_vec", 0, 4, 0, -1);

        $display("[TB] zero-length run");
        apply_stimulus("zero_run", 0, 0, 0, -1);

        $display("[TB] gapped run of three");
        for (int i = 0; i < 3; i++) begin
            op_a[i] = 8'($urandom); op_b[i] = 8'($urandom); mask[i] = 8'h00;
        end
        apply_stimulus("gapped", 0, 3, 1, -1);

        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, 40);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                op_a[i] = 8'($urandom);
                op_b[i] = 8'($urandom);
                mask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            apply_stimulus($sformatf("rand%0d", r), 0, n, gap, -1);
        end

        $display("[TB] reset during run");
        @(negedge clk);
        start = 1'b1; num_vectors = 8'd10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; op_a_in = 8'($urandom); op_b_in = 8'($urandom); corrupt = 8'h00;
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        #1;
        check_output("async_rst_l1", 32'({busy1, done1, pass1, vc1, ec1, ff1}), 32'd0);
        check_output("async_rst_l2", 32'({busy2, done2, pass2, vc2, ec2, ff2}), 32'd0);
        #9;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("post_rst_idle_l1", 32'({busy1, done1}), 32'd0);
        check_output("post_rst_idle_l2", 32'({busy2, done2}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            op_a[i] = 8'($urandom); op_b[i] = 8'($urandom); mask[i] = 8'h00;
        end
        apply_stimulus("after_rst", 0, 2, 0, -1);

        $display("[TB] 300 mismatching vectors in runs of 255 and 45");
        for (int i = 0; i < 300; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
            mask[i] = 8'($urandom_range(1, 255));
        end
        apply_stimulus("sat_run", 0, 255, 0, 100);
        apply_stimulus("tail_run", 255, 45, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a hung handshake still yields a failure line and the summary.
    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
